counter_synth_wrapper: RTL and testbench
========================================

Name: counter_synth_wrapper

Overview:
- Synthesis top-level wrapper around a free-running WIDTH-bit up/down counter.
- sel_i selects the count direction: 0 = up, 1 = down.
- sel_i is treated as asynchronous to clk and passes through a synchronizer before it steers the counter.
- The count register drives data_o directly; the block is a self-contained leaf used for synthesis and timing characterisation.

Parameters:
- WIDTH, 4, counter and data_o width in bits (legal range 2 to 32).
- SYNC_STAGES, 2, number of flops in the sel_i synchronizer (legal range 1 to 4).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-high reset. The codebase name is kept; reset is asserted when rst_n = 1.
- sel_i  input  1  direction select: 0 = count up, 1 = count down. May be asynchronous to clk.
- data_o  output  WIDTH  current counter value.

Behaviour:
- Reset (rst_n = 1, asynchronous):
  - count resets to 0, so data_o = 0 immediately, with no clock edge needed.
  - All synchronizer flops reset to 0, i.e. direction up.
  - While reset is held, the count stays 0 regardless of clk or sel_i.
- Synchronizer:
  - sel_i is shifted through SYNC_STAGES flops.
  - dir = last stage.
  - A change on sel_i becomes visible in dir after SYNC_STAGES rising edges.
- Counter update, every rising edge of clk while rst_n = 0:
  - dir = 0: count <= count + 1 modulo 2^WIDTH.
  - dir = 1: count <= count - 1 modulo 2^WIDTH.
- No enable input: the counter advances on every edge out of reset.
- Wrap-around:
  - Up from 2^WIDTH-1 goes to 0 (WIDTH = 4: 15 -> 0).
  - Down from 0 goes to 2^WIDTH-1 (0 -> 15).
  - No saturation and no flags.
- Direction change:
  - The count edge that uses the new dir produces the new direction's value relative to the current count.
  - No skipped or repeated values other than the reversal itself (example: 5, 6, 7 then reversal gives 6, 5).
- Reset release:
  - The first rising edge after rst_n falls to 0 applies the synchronizer's current dir.
  - Because the synchronizer resets to up, the first SYNC_STAGES post-reset edges count up even if sel_i = 1.
  - Example (SYNC_STAGES = 2, sel_i = 1): 0, 1, 2, then down 1, 0, 15.
- Reset mid-operation: count and synchronizer clear asynchronously; counting resumes from 0 as above.
- data_o is a registered output: no combinational path from sel_i to data_o.

Decomposition:
- Package counter_pkg:
  - localparam DIR_UP = 1'b0, DIR_DOWN = 1'b1.
  - Default width constant COUNTER_WIDTH_DEFAULT = 4.
- Sub-module updown_counter_core:
  - Ports: clk, rst_n, dir_i, count_o; parameter WIDTH.
  - Holds the count register and the wrap arithmetic.
- The wrapper contains the sel_i synchronizer and one core instance.

Test Plan:
- Reset: assert rst_n = 1 mid-count (count = 9), asynchronously between edges -> data_o = 0 before the next edge; stays 0 for 3 clocks.
- Up count: release reset with sel_i = 0 -> data_o = 1, 2, ... 15, 0, 1 on successive edges; wrap 15 -> 0 checked.
- Down count: hold sel_i = 1 for more than 20 edges after reset -> after 2 up steps (0 -> 1 -> 2), sequence 1, 0, 15, 14, ...; wrap 0 -> 15 checked.
- Reversal latency: count up to 7, set sel_i = 1 just after an edge -> data_o = 8, 9, then 8, 7 (two-edge synchronizer delay), then back to up at the same latency.
- Long run:
  - 20 clocks up from reset, then sel_i = 1 -> value 4 at the switch (20 mod 16), 5, 6, then 5, 4, 3.
  - Scoreboard model matches every cycle.
- Parameter sweep: WIDTH = 8, SYNC_STAGES = 3 -> wrap 255 -> 0 and 0 -> 255; direction change visible after 3 edges.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg                                                          |
// | Shared constants for the up/down counter synthesis wrapper.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int COUNTER_WIDTH_DEFAULT = 4;
    localparam int SYNC_STAGES_DEFAULT   = 2;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_synth_wrapper_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_synth_wrapper_if                                             |
// | Direction-select input and count output of the counter wrapper.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface counter_synth_wrapper_if #(
    parameter int WIDTH = 4
);

    logic             sel_i;
    logic [WIDTH-1:0] data_o;

    // The master drives direction and observes the count; the slave is the wrapper.
    modport master (
        output sel_i,
        input  data_o
    );

    modport slave (
        input  sel_i,
        output data_o
    );

endinterface : counter_synth_wrapper_if
`default_nettype wire

// File: rtl/updown_counter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | updown_counter_core                                                  |
// | WIDTH-bit free-running counter with modulo-2^WIDTH up/down wrap.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module updown_counter_core
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             dir_i,
    output logic [WIDTH-1:0]      count_o
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Unsigned arithmetic truncated to WIDTH gives the wrap in both directions.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_count <= '0;
        end else if (dir_i == DIR_DOWN) begin
            r_count <= r_count - c_one;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign count_o = r_count;

endmodule : updown_counter_core
`default_nettype wire

// File: rtl/counter_synth_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_synth_wrapper                                                |
// | Synthesis top: sel_i synchronizer feeding one up/down counter core.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module counter_synth_wrapper
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNTER_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    counter_synth_wrapper_if.slave bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_dir;
    logic [WIDTH-1:0]       w_count;

    // Reset value of every stage is DIR_UP, so the first SYNC_STAGES edges count up.
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    r_sync <= {SYNC_STAGES{DIR_UP}};
                end else begin
                    r_sync[0] <= bus.sel_i;
                end
            end
        end else begin : g_sync_multi
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    r_sync <= {SYNC_STAGES{DIR_UP}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sel_i};
                end
            end
        end
    endgenerate

    assign w_dir = r_sync[SYNC_STAGES-1];

    updown_counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .dir_i   (w_dir),
        .count_o (w_count)
    );

    assign bus.data_o = w_count;

endmodule : counter_synth_wrapper
`default_nettype wire

// File: tb/tb_counter_synth_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_synth_wrapper                                             |
// | Two wrapper configurations checked against a sel-history model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_counter_synth_wrapper;

    localparam int WA = 4;
    localparam int SA = 2;
    localparam int WB = 8;
    localparam int SB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int vectors    = 0;
    int miscompares = 0;

    counter_synth_wrapper_if #(.WIDTH(WA)) ifa ();
    counter_synth_wrapper_if #(.WIDTH(WB)) ifb ();

    counter_synth_wrapper #(.WIDTH(WA), .SYNC_STAGES(SA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    counter_synth_wrapper #(.WIDTH(WB), .SYNC_STAGES(SB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    // Model: the direction used on edge n is sel_i as sampled on edge n-SYNC_STAGES,
    // or up if that edge precedes the last reset release.
    int  ma = 0;
    int  mb = 0;
    bit  ha[$];
    bit  hb[$];

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ma = 0;
            mb = 0;
            ha.delete();
            hb.delete();
        end else begin
            ha.push_back(ifa.sel_i);
            hb.push_back(ifb.sel_i);
            if (ha.size() > SA && ha[ha.size()-SA-1]) ma = (ma + (1 << WA) - 1) % (1 << WA);
            else                                       ma = (ma + 1) % (1 << WA);
            if (hb.size() > SB && hb[hb.size()-SB-1]) mb = (mb + (1 << WB) - 1) % (1 << WB);
            else                                       mb = (mb + 1) % (1 << WB);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: data_o=%0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_a", int'(ifa.data_o), ma);
        check("model_b", int'(ifb.data_o), mb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic sa, input logic sb);
        rst_n = 1'b1;
        ifa.sel_i = sa;
        ifb.sel_i = sb;
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        ifa.sel_i = 1'b0;
        ifb.sel_i = 1'b0;
        repeat (3) tick();
        check("reset_a", int'(ifa.data_o), 0);
        check("reset_b", int'(ifb.data_o), 0);

        // Up count through the 15 -> 0 wrap.
        rst_n = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("up_a", int'(ifa.data_o), k % 16);
        end
        for (int k = 2; k <= 9; k++) begin
            tick();
            check("up_to9_a", int'(ifa.data_o), k);
        end

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b1;
        #1;
        check("async_rst_a", int'(ifa.data_o), 0);
        check("async_rst_b", int'(ifb.data_o), 0);
        ifa.sel_i = 1'b1;
        repeat (3) begin
            tick();
            check("rst_hold_a", int'(ifa.data_o), 0);
        end

        // Down count from reset: two up steps, then down through 0 -> 15.
        rst_n = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            check("down_a", int'(ifa.data_o), (k <= 2) ? k : (((4 - k) % 16) + 16) % 16);
        end

        // Reversal latency both ways.
        restart(1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("rev_up_a", int'(ifa.data_o), k);
        end
        ifa.sel_i = 1'b1;
        tick(); check("rev_dn0_a", int'(ifa.data_o), 8);
        tick(); check("rev_dn1_a", int'(ifa.data_o), 9);
        tick(); check("rev_dn2_a", int'(ifa.data_o), 8);
        tick(); check("rev_dn3_a", int'(ifa.data_o), 7);
        ifa.sel_i = 1'b0;
        tick(); check("rev_up0_a", int'(ifa.data_o), 6);
        tick(); check("rev_up1_a", int'(ifa.data_o), 5);
        tick(); check("rev_up2_a", int'(ifa.data_o), 6);
        tick(); check("rev_up3_a", int'(ifa.data_o), 7);

        // Long run: 20 up edges, then reverse.
        restart(1'b0, 1'b0);
        repeat (20) tick();
        check("long_sw_a", int'(ifa.data_o), 4);
        ifa.sel_i = 1'b1;
        tick(); check("long_1_a", int'(ifa.data_o), 5);
        tick(); check("long_2_a", int'(ifa.data_o), 6);
        tick(); check("long_3_a", int'(ifa.data_o), 5);
        tick(); check("long_4_a", int'(ifa.data_o), 4);
        tick(); check("long_5_a", int'(ifa.data_o), 3);

        // WIDTH = 8, SYNC_STAGES = 3.
        restart(1'b0, 1'b0);
        repeat (255) tick();
        check("b_255", int'(ifb.data_o), 255);
        tick();
        check("b_wrap_up", int'(ifb.data_o), 0);
        ifb.sel_i = 1'b1;
        tick(); check("b_lat1", int'(ifb.data_o), 1);
        tick(); check("b_lat2", int'(ifb.data_o), 2);
        tick(); check("b_lat3", int'(ifb.data_o), 3);
        tick(); check("b_dn1", int'(ifb.data_o), 2);
        tick(); check("b_dn2", int'(ifb.data_o), 1);
        tick(); check("b_dn3", int'(ifb.data_o), 0);
        tick(); check("b_wrap_dn", int'(ifb.data_o), 255);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter_synth_wrapper
`default_nettype wire
